image_pingpong_buf: RTL and testbench

Double-buffered (ping-pong) image store between the UART/host pixel loader and the LeNet inference engine. A byte stream with valid/ready fills one bank while inference reads the other through an asynchronous random-access port, so loading frame N+1 overlaps inference on frame N. Pixel width, frame depth and address width are parameters. Default is 28x28 = 784 bytes per bank, in distributed RAM.

---
 rtl/image_buf_pkg.sv | 8 +
 rtl/image_bank.sv | 40 ++++
 rtl/image_pingpong_buf.sv | 125 ++++++++++++
 tb/tb_image_pingpong_buf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/image_buf_pkg.sv
// Shared constants for the ping-pong image buffer.
// Defaults describe one 28x28 8-bit frame per bank.
package image_buf_pkg;
  localparam int unsigned IMG_DEPTH   = 784;
  localparam int unsigned IMG_DATA_W  = 8;
  localparam int unsigned IMG_ADDR_W  = 10;
  localparam int unsigned FRAME_CNT_W = 16;
endpackage

// File: rtl/image_bank.sv
// One distributed-RAM image bank, DATA_W x DEPTH.
// Ports: clk; we/wr_addr/wr_data synchronous write; rd_addr/rd_data
// asynchronous read (out-of-range reads give 0). With IMAGE_BUF_DBG_EN
// defined, dbg_addr/dbg_data form a second asynchronous read port.
module image_bank
  import image_buf_pkg::*;
#(
  parameter int unsigned DATA_W = IMG_DATA_W,
  parameter int unsigned DEPTH  = IMG_DEPTH,
  parameter int unsigned ADDR_W = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef IMAGE_BUF_DBG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = (rd_addr <= LAST) ? mem[rd_addr] : '0;

`ifdef IMAGE_BUF_DBG_EN
  assign dbg_data = (dbg_addr <= LAST) ? mem[dbg_addr] : '0;
`endif

endmodule

// File: rtl/image_pingpong_buf.sv
// Ping-pong image store: the loader stream fills one bank while the
// consumer reads the other asynchronously.
// Ports: clk, rst (async, active-high); in_data/in_valid/in_sof/in_ready
// loader stream; frame_valid/frame_done/rd_addr/rd_data consumer side;
// frame_cnt completed frames (wraps); sof_resync sticky abandoned-frame flag.
// Optional macro IMAGE_BUF_DBG_EN adds dbg_bank/dbg_addr/dbg_data, an
// asynchronous read of either bank independent of rd_bank and full.
module image_pingpong_buf
  import image_buf_pkg::*;
#(
  parameter int unsigned DATA_W = IMG_DATA_W,
  parameter int unsigned DEPTH  = IMG_DEPTH,
  parameter int unsigned ADDR_W = IMG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic                   frame_valid,
  input  logic                   frame_done,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   sof_resync
`ifdef IMAGE_BUF_DBG_EN
  ,
  input  logic                   dbg_bank,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data
`endif
);

  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam logic              DEPTH_ONE = (DEPTH == 1);

  logic [1:0]        full, full_nxt;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic              accept, complete, release_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  // Flags come straight from registers: no path from in_valid to in_ready.
  assign in_ready    = !full[wr_bank];
  assign frame_valid = full[rd_bank];

  assign accept       = in_valid && in_ready;
  assign wr_addr      = in_sof ? '0 : wr_ptr;
  // An SOF beat only finishes a frame when a frame is a single pixel.
  assign complete     = accept && (in_sof ? DEPTH_ONE : (wr_ptr == LAST));
  assign release_bank = frame_done && full[rd_bank];

  // Completion and release always target different banks: completion needs
  // full[wr_bank]=0 while release needs full[rd_bank]=1.
  always_comb begin
    full_nxt   = full;
    wr_ptr_nxt = wr_ptr;
    if (complete)     full_nxt[wr_bank] = 1'b1;
    if (release_bank) full_nxt[rd_bank] = 1'b0;
    if (accept) begin
      if (complete)    wr_ptr_nxt = '0;
      else if (in_sof) wr_ptr_nxt = ADDR_W'(1);
      else             wr_ptr_nxt = wr_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_ptr     <= '0;
      frame_cnt  <= '0;
      sof_resync <= 1'b0;
    end else begin
      full   <= full_nxt;
      wr_ptr <= wr_ptr_nxt;
      if (complete) begin
        wr_bank   <= !wr_bank;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      if (release_bank) rd_bank <= !rd_bank;
      // A restart mid-frame silently drops the partial frame.
      if (accept && in_sof && (wr_ptr != '0)) sof_resync <= 1'b1;
    end
  end

`ifdef IMAGE_BUF_DBG_EN
  logic [DATA_W-1:0] dbg_data0, dbg_data1;
  assign dbg_data = dbg_bank ? dbg_data1 : dbg_data0;
`endif

  image_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk      (clk),
    .we       (accept && !wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (in_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data0)
`ifdef IMAGE_BUF_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data0)
`endif
  );

  image_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk      (clk),
    .we       (accept && wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (in_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data1)
`ifdef IMAGE_BUF_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data1)
`endif
  );

  assign rd_data = rd_bank ? rd_data1 : rd_data0;

endmodule

// File: tb/tb_image_pingpong_buf.sv
// Directed self-checking bench for image_pingpong_buf (default 784x8 banks).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_image_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic        frame_valid;
  logic        frame_done;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] frame_cnt;
  logic        sof_resync;
`ifdef IMAGE_BUF_DBG_EN
  logic        dbg_bank;
  logic [9:0]  dbg_addr;
  logic [7:0]  dbg_data;
`endif

  int errors = 0;
  int checks = 0;
  bit stalled;

  always #5 clk = ~clk;

  image_pingpong_buf #(.DATA_W(8), .DEPTH(784), .ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_cnt   (frame_cnt),
    .sof_resync  (sof_resync)
`ifdef IMAGE_BUF_DBG_EN
    ,
    .dbg_bank    (dbg_bank),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream n beats; ramp=1 sends base+i, else constant base.
  task automatic send_beats(input int n, input logic [7:0] base, input bit ramp,
                            input bit sof_first, input bit done_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!in_ready) stalled = 1'b1;
      in_valid   = 1'b1;
      in_data    = ramp ? 8'(base + 8'(i)) : base;
      in_sof     = sof_first && (i == 0);
      frame_done = done_last && (i == n - 1);
    end
    @(negedge clk);
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
    frame_done = 1'b0; rd_addr = '0; stalled = 1'b0;
`ifdef IMAGE_BUF_DBG_EN
    dbg_bank = 1'b0; dbg_addr = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_sof_resync", 32'(sof_resync), 32'd0);

    // Ramp frame into bank 0; frame_valid must stay low until the last beat.
    send_beats(783, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t1_not_valid_early", 32'(frame_valid), 32'd0);
    send_beats(1, 8'h0F, 1'b0, 1'b0, 1'b0);
    check("t1_frame_valid", 32'(frame_valid), 32'd1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_no_stall", 32'(stalled), 32'd0);
    read_check("t1_rd_783", 10'd783, 8'h0F);
    read_check("t1_rd_0", 10'd0, 8'h00);
    read_check("t1_rd_300", 10'd300, 8'h2C);
    read_check("t1_rd_oob", 10'd784, 8'h00);
    pulse_done();
    check("t1_released", 32'(frame_valid), 32'd0);

    // Two frames back to back with no release: both banks fill.
    send_beats(784, 8'hAA, 1'b0, 1'b1, 1'b0);
    send_beats(784, 8'h55, 1'b0, 1'b1, 1'b0);
    check("t2_in_ready_low", 32'(in_ready), 32'd0);
    check("t2_frame_valid", 32'(frame_valid), 32'd1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd3);
    read_check("t2_rd_aa", 10'd10, 8'hAA);
    // A beat offered while stalled must be ignored.
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h99;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    check("t2_stall_cnt", 32'(frame_cnt), 32'd3);
    read_check("t2_stall_nowrite", 10'd0, 8'hAA);
    @(negedge clk);
    frame_done = 1'b1;
    check("t2_ready_before", 32'(in_ready), 32'd0);
    @(negedge clk);
    frame_done = 1'b0;
    check("t2_ready_after", 32'(in_ready), 32'd1);
    check("t2_valid_after", 32'(frame_valid), 32'd1);
    read_check("t2_rd_55", 10'd10, 8'h55);

    // Last beat of the next frame coincides with releasing the 0x55 frame.
    stalled = 1'b0;
    send_beats(784, 8'h3C, 1'b0, 1'b1, 1'b1);
    check("t5_frame_valid", 32'(frame_valid), 32'd1);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd4);
    check("t5_no_stall", 32'(stalled), 32'd0);
    read_check("t5_rd_3c", 10'd5, 8'h3C);

    // Abandon a partial frame with a new SOF.
    send_beats(100, 8'h11, 1'b0, 1'b1, 1'b0);
    check("t3_no_resync_yet", 32'(sof_resync), 32'd0);
    send_beats(1, 8'h77, 1'b0, 1'b1, 1'b0);
    send_beats(783, 8'h22, 1'b0, 1'b0, 1'b0);
    check("t3_sof_resync", 32'(sof_resync), 32'd1);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd5);
    check("t3_both_full", 32'(in_ready), 32'd0);
    pulse_done();
    check("t3_ready", 32'(in_ready), 32'd1);
    read_check("t3_rd_0", 10'd0, 8'h77);
    read_check("t3_rd_1", 10'd1, 8'h22);
    read_check("t3_rd_99", 10'd99, 8'h22);
    read_check("t3_rd_783", 10'd783, 8'h22);

    // frame_done with no valid frame must not move rd_bank.
    pulse_done();
    check("t4_empty", 32'(frame_valid), 32'd0);
    pulse_done();
    check("t4_still_empty", 32'(frame_valid), 32'd0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd5);
    send_beats(784, 8'hC3, 1'b0, 1'b1, 1'b0);
    check("t4_valid_same_bank", 32'(frame_valid), 32'd1);
    check("t4_frame_cnt2", 32'(frame_cnt), 32'd6);
    read_check("t4_rd_c3", 10'd3, 8'hC3);

    // Asynchronous reset mid-frame.
    send_beats(400, 8'h01, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(in_ready), 32'd1);
    check("t6_rst_valid", 32'(frame_valid), 32'd0);
    check("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    check("t6_rst_resync", 32'(sof_resync), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_beats(1, 8'hE1, 1'b0, 1'b0, 1'b0);
    send_beats(783, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t6_valid", 32'(frame_valid), 32'd1);
    check("t6_cnt", 32'(frame_cnt), 32'd1);
    read_check("t6_rd_0", 10'd0, 8'hE1);
    read_check("t6_rd_1", 10'd1, 8'h00);
`ifdef IMAGE_BUF_DBG_EN
    dbg_bank = 1'b1; dbg_addr = 10'd5;
    #1 check("dbg_bank1", 32'(dbg_data), 32'hC3);
    dbg_bank = 1'b0; dbg_addr = 10'd0;
    #1 check("dbg_bank0", 32'(dbg_data), 32'hE1);
    dbg_addr = 10'd900;
    #1 check("dbg_oob", 32'(dbg_data), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
